// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the MIPS32 memory arbiter.
//   state_e  - arbiter FSM states (IDLE / ACCESS / RESP)
//   owner_e  - which pipeline stage owns the current bus access
//   CNT_W    - wait-state counter width (covers WAIT_CYCLES up to 15)
//   SEL_ALL  - full-word byte enables used for instruction fetches
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_e;

   typedef enum logic {
      OWN_IF,
      OWN_MEM
   } owner_e;

   localparam int unsigned CNT_W   = $clog2(16);
   localparam logic [3:0]  SEL_ALL = 4'b1111;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the pipeline-side request/ack signals and the
// external bus signals of mem_arbiter. Signal suffixes are from the arbiter's
// point of view.
//   slave  - used by mem_arbiter (consumes requests and bus read data)
//   master - used by the pipeline / bus model side
// Signals:
//   if_req_i, if_addr_i, if_rdata_o, if_ack_o, if_stall_o      instruction fetch
//   mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
//   mem_rdata_o, mem_ack_o, mem_stall_o                        data access
//   bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
//   bus_rdata_i                                                external SRAM/bus
interface mem_arbiter_if;

   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_rdata_o;
   logic        if_ack_o;
   logic        if_stall_o;

   logic        mem_req_i;
   logic        mem_we_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic [31:0] mem_rdata_o;
   logic        mem_ack_o;
   logic        mem_stall_o;

   logic        bus_ce_o;
   logic        bus_we_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i;

   modport slave (
      input  if_req_i, if_addr_i,
      input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
      input  bus_rdata_i,
      output if_rdata_o, if_ack_o, if_stall_o,
      output mem_rdata_o, mem_ack_o, mem_stall_o,
      output bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o
   );

   modport master (
      output if_req_i, if_addr_i,
      output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
      output bus_rdata_i,
      input  if_rdata_o, if_ack_o, if_stall_o,
      input  mem_rdata_o, mem_ack_o, mem_stall_o,
      input  bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o
   );

endinterface

// File: rtl/mem_arb_ibuf.sv
// mem_arb_ibuf: single-entry instruction fetch buffer (word tag, data, valid).
// Only instantiated by mem_arbiter when MEM_ARB_IBUF_EN is defined.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears valid)
//   fill_i          load tag/data from a completed fetch bus access
//   fill_word_i     word address (addr[31:2]) of the completed fetch
//   fill_data_i     instruction word returned by the bus
//   inval_i         a data write is completing
//   inval_word_i    word address of that write; clears valid on tag match
//   lookup_word_i   word address of the pending fetch request
//   hit_o           buffer holds the requested word
//   data_o          buffered instruction word
module mem_arb_ibuf
   import mem_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        fill_i,
   input  logic [29:0] fill_word_i,
   input  logic [31:0] fill_data_i,
   input  logic        inval_i,
   input  logic [29:0] inval_word_i,
   input  logic [29:0] lookup_word_i,
   output logic        hit_o,
   output logic [31:0] data_o
);

   logic [29:0] tag_q;
   logic [31:0] data_q;
   logic        valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (fill_i) begin
         tag_q   <= fill_word_i;
         data_q  <= fill_data_i;
         valid_q <= 1'b1;
      end else if (inval_i && (inval_word_i == tag_q)) begin
         valid_q <= 1'b0;
      end
   end

   assign hit_o  = valid_q && (lookup_word_i == tag_q);
   assign data_o = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external SRAM/bus port between instruction fetch
// (IF) and data access (MEM). Each access is held on the bus for WAIT_CYCLES
// cycles, then the owner gets a one-cycle ack with its read data. MEM wins
// simultaneous requests. Stall outputs hold each stage until its ack.
// Parameters:
//   WAIT_CYCLES     bus cycles per access, 1..15
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   arb             mem_arbiter_if.slave (IF/MEM request side + bus side)
// Build option:
//   MEM_ARB_IBUF_EN adds a single-entry fetch buffer (mem_arb_ibuf); IF
//                   requests hitting it are acked one cycle later with no
//                   bus access.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave arb
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   state_e           state_q;
   owner_e           owner_q;
   logic [CNT_W-1:0] cnt_q;
   logic             flush_q;
   logic             bus_ce_q;
   logic             bus_we_q;
   logic [3:0]       bus_sel_q;
   logic [31:0]      bus_addr_q;
   logic [31:0]      bus_wdata_q;
   logic [31:0]      if_rdata_q;
   logic [31:0]      mem_rdata_q;
   logic             if_ack_q;
   logic             mem_ack_q;

   logic             owner_req;
   logic             last_cycle;

   assign owner_req  = (owner_q == OWN_MEM) ? arb.mem_req_i : arb.if_req_i;
   assign last_cycle = (state_q == ACCESS) && (cnt_q == '0);

`ifdef MEM_ARB_IBUF_EN
   logic        ibuf_hit;
   logic [31:0] ibuf_data;

   // The latched bus command stays valid through RESP, so it also supplies
   // the write address for invalidation.
   mem_arb_ibuf u_ibuf (
      .clk           (clk),
      .rst           (rst),
      .fill_i        (last_cycle && (owner_q == OWN_IF)),
      .fill_word_i   (bus_addr_q[31:2]),
      .fill_data_i   (arb.bus_rdata_i),
      .inval_i       ((state_q == RESP) && (owner_q == OWN_MEM) && bus_we_q),
      .inval_word_i  (bus_addr_q[31:2]),
      .lookup_word_i (arb.if_addr_i[31:2]),
      .hit_o         (ibuf_hit),
      .data_o        (ibuf_data)
   );
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         cnt_q       <= '0;
         flush_q     <= 1'b0;
         bus_ce_q    <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_sel_q   <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_ack_q    <= 1'b0;
         mem_ack_q   <= 1'b0;
      end else begin
         if_ack_q  <= 1'b0;
         mem_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (arb.mem_req_i) begin
                  owner_q     <= OWN_MEM;
                  bus_we_q    <= arb.mem_we_i;
                  bus_sel_q   <= arb.mem_sel_i;
                  bus_addr_q  <= arb.mem_addr_i;
                  bus_wdata_q <= arb.mem_wdata_i;
                  bus_ce_q    <= 1'b1;
                  cnt_q       <= CNT_LOAD;
                  flush_q     <= 1'b0;
                  state_q     <= ACCESS;
               end
`ifdef MEM_ARB_IBUF_EN
               else if (arb.if_req_i && ibuf_hit) begin
                  // Buffer hit skips the bus; owner is IF so RESP never
                  // invalidates on a stale write command.
                  owner_q    <= OWN_IF;
                  if_rdata_q <= ibuf_data;
                  if_ack_q   <= 1'b1;
                  state_q    <= RESP;
               end
`endif
               else if (arb.if_req_i) begin
                  owner_q     <= OWN_IF;
                  bus_we_q    <= 1'b0;
                  bus_sel_q   <= SEL_ALL;
                  bus_addr_q  <= arb.if_addr_i;
                  bus_wdata_q <= '0;
                  bus_ce_q    <= 1'b1;
                  cnt_q       <= CNT_LOAD;
                  flush_q     <= 1'b0;
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               // A requester that drops out at any point of the access
               // loses its ack, but the bus cycle itself runs to the end.
               if (!owner_req) begin
                  flush_q <= 1'b1;
               end
               if (cnt_q == '0) begin
                  bus_ce_q <= 1'b0;
                  state_q  <= RESP;
                  if (owner_q == OWN_MEM) begin
                     mem_rdata_q <= bus_we_q ? '0 : arb.bus_rdata_i;
                     mem_ack_q   <= owner_req & ~flush_q;
                  end else begin
                     if_rdata_q <= arb.bus_rdata_i;
                     if_ack_q   <= owner_req & ~flush_q;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign arb.if_rdata_o  = if_rdata_q;
   assign arb.if_ack_o    = if_ack_q;
   assign arb.mem_rdata_o = mem_rdata_q;
   assign arb.mem_ack_o   = mem_ack_q;
   assign arb.bus_ce_o    = bus_ce_q;
   assign arb.bus_we_o    = bus_we_q;
   assign arb.bus_sel_o   = bus_sel_q;
   assign arb.bus_addr_o  = bus_addr_q;
   assign arb.bus_wdata_o = bus_wdata_q;
   assign arb.if_stall_o  = arb.if_req_i & ~if_ack_q;
   assign arb.mem_stall_o = arb.mem_req_i & ~mem_ack_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the MIPS32 pipeline. It shares one external SRAM/bus port between instruction fetch (IF) and data access (MEM), sequences each access through a fixed wait-state count, and returns data with an ack pulse. It raises per-stage stall requests to the pipeline controller so that IF and MEM hold until their access completes.

## Interface
- `WAIT_CYCLES`, default 1: bus cycles per access; legal range 1..15.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req_i` in 1: IF fetch request; held until `if_ack_o`.
- `if_addr_i` in 32: fetch address, word-aligned.
- `if_rdata_o` out 32: fetched instruction; valid while `if_ack_o`=1.
- `if_ack_o` out 1: one-cycle completion pulse for IF.
- `mem_req_i` in 1: MEM request; held until `mem_ack_o`.
- `mem_we_i` in 1: 1 = write, 0 = read.
- `mem_sel_i` in 4: byte enables.
- `mem_addr_i` in 32: data address.
- `mem_wdata_i` in 32: write data.
- `mem_rdata_o` out 32: read data; valid while `mem_ack_o`=1.
- `mem_ack_o` out 1: one-cycle completion pulse for MEM.
- `bus_ce_o` out 1: bus chip enable.
- `bus_we_o` out 1: bus write enable.
- `bus_sel_o` out 4: bus byte enables; 4'b1111 for IF.
- `bus_addr_o` out 32: bus address.
- `bus_wdata_o` out 32: bus write data; 0 for IF.
- `bus_rdata_i` in 32: bus read data, sampled in the last access cycle.
- `if_stall_o` out 1: `if_req_i & ~if_ack_o` (combinational).
- `mem_stall_o` out 1: `mem_req_i & ~mem_ack_o` (combinational).

## Operation
- States:
  - IDLE: no access in progress.
  - ACCESS: bus driven; wait counter running.
  - RESP: ack pulse cycle.
- IDLE:
  - If any request is present, latch the owner, latch the command (addr/we/sel/wdata), load the counter with WAIT_CYCLES-1, and go to ACCESS.
  - Priority: MEM over IF, because MEM holds the older instruction. Simultaneous requests grant MEM first; IF is served on the next arbitration.
- ACCESS:
  - Bus outputs are driven from the latched command, with `bus_ce_o`=1.
  - Counter decrements each cycle.
  - At counter 0: capture `bus_rdata_i` into the owner's rdata register and go to RESP.
- RESP:
  - Pulse the owner's ack and drop `bus_ce_o`.
  - Always return to IDLE; no re-grant in this cycle.
- A write ack carries `mem_rdata_o`=0.
- Requester drops its request mid-ACCESS (flush):
  - The bus access still completes, so no partial write occurs.
  - The ack is suppressed in RESP.
  - The FSM returns to IDLE.
- Non-owner request changes during ACCESS are ignored until IDLE.
- `rdata_o` registers hold their value until the next capture. Only the ack qualifies them.
- Reset (any time, including mid-access):
  - State IDLE, counter 0.
  - All outputs 0, including rdata, ack, and bus_*.
  - Latched command cleared.
  - No ack is produced for the aborted access.

## Timing
- Request seen high at edge N (IDLE) gives:
  - `bus_ce_o`=1 for cycles N+1 .. N+WAIT_CYCLES.
  - Ack high in cycle N+WAIT_CYCLES+1.
- Latency from request to ack is WAIT_CYCLES+1 cycles.
- Peak throughput is one access per WAIT_CYCLES+2 cycles.
- Bus outputs are registered; they change only on clock edges.
- Stall outputs are combinational from the request and ack, so they deassert in the ack cycle. The pipeline advances on the following edge.

## Configuration
- `MEM_ARB_IBUF_EN` defined: adds a single-entry fetch buffer (address tag, data, valid).
  - IF request in IDLE whose address matches the valid tag: ack next cycle with the buffered data, no bus access.
  - Latency in this case is 1 cycle, even when MEM is not requesting.
  - MEM has priority: an IF hit is only served when `mem_req_i`=0.
  - Every completed IF bus access refills the buffer.
  - A MEM write to the tagged word address (addr[31:2]) clears valid in its RESP cycle.
  - Reset clears valid.
- Undefined: every IF request goes to the bus. The buffer logic is not present.

## Structure
- Package `mem_arb_pkg` holds:
  - State enum: IDLE/ACCESS/RESP.
  - Owner enum: OWN_IF/OWN_MEM.
  - Counter width constant `$clog2(16)`.
  - Constant `SEL_ALL` = 4'b1111.
- Sub-module `mem_arb_ibuf` (tag/data/valid, hit compare, invalidate) is instantiated only under `MEM_ARB_IBUF_EN`.

## Test plan
- Reset mid-ACCESS with WAIT_CYCLES=3: all outputs 0 next cycle, no ack, FSM IDLE.
- IF read 0x0000_0100, `bus_rdata_i`=0x3421_FFFF, WAIT_CYCLES=2: `bus_ce_o` high 2 cycles, `if_ack_o` in cycle 3 with 0x3421_FFFF, `if_stall_o` high cycles 0..2.
- IF and MEM requests in the same cycle:
  - MEM write (addr 0x80, sel 4'b0011, data 0xDEAD_BEEF) served first with `bus_we_o`=1.
  - IF is granted at the IDLE after MEM's RESP.
- IF request dropped in ACCESS cycle 1: bus access completes, `if_ack_o` never pulses, next MEM request proceeds normally.
- `MEM_ARB_IBUF_EN`:
  - Fetch 0x200 twice: second ack 1 cycle after request with no `bus_ce_o`.
  - MEM write to 0x200: third fetch goes to the bus.
- WAIT_CYCLES=15, back-to-back MEM reads: acks spaced exactly 17 cycles apart.
